score_player: RTL and testbench



---
 rtl/score_player.sv | 158 +++++++++++++++
 tb/tb_score_player.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : score_player
// Description : Steps ibeatNum through a score at a fixed quarter-beat tempo,
//               registers the returned tone and synthesises a 50%-duty square
//               wave at that frequency, with play/pause/restart/loop control.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module score_player #(
  parameter int CLK_FREQ       = 100000000,
  parameter int BEAT_FREQ      = 8,
  parameter int LAST_BEAT      = 255,
  parameter int SILENCE_THRESH = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        restart,
  input  logic        loop_en,
  input  logic [31:0] tone,
  output logic [7:0]  ibeatNum,
  output logic        audio,
  output logic        playing,
  output logic        done
);

  localparam int unsigned C_DIV       = CLK_FREQ / BEAT_FREQ;
  localparam logic [31:0] C_PRESC_MAX = 32'(C_DIV - 1);
  localparam logic [32:0] C_CLK       = 33'(CLK_FREQ);
  localparam logic [31:0] C_SILENCE   = 32'(SILENCE_THRESH);
  localparam logic [7:0]  C_LAST      = 8'(LAST_BEAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_presc;
  logic [31:0] w_presc_next;
  logic [7:0]  w_beat_next;
  logic [31:0] r_tone_q;
  logic [31:0] w_tone_next;
  logic [32:0] r_acc;
  logic [32:0] w_acc_next;
  logic        r_wave;
  logic        w_wave_next;
  logic        w_tick;
  logic        w_last;
  logic        w_silent;
  logic [32:0] w_step;
  logic [32:0] w_sum;

  // Tempo tick only exists while playing; the prescaler is frozen elsewhere.
  assign w_tick   = (r_state == PLAY) && (r_presc == C_PRESC_MAX);
  assign w_last   = (ibeatNum == C_LAST);
  // Accumulating 2*f per cycle against CLK_FREQ toggles at 2*f, giving f Hz.
  assign w_step   = {r_tone_q, 1'b0};
  assign w_sum    = r_acc + w_step;
  // Rests, zero and anything at or above Nyquist-for-a-toggle are silent.
  assign w_silent = (r_tone_q >= C_SILENCE) || (r_tone_q == 32'd0) || (w_step >= C_CLK);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: restart beats end-of-score, which beats pause.
  always_comb begin
    w_state_next = r_state;
    if (restart) begin
      w_state_next = play ? PLAY : IDLE;
    end else begin
      case (r_state)
        IDLE:  if (play) w_state_next = PLAY;
        PLAY: begin
          if (w_tick && w_last && !loop_en) begin
            w_state_next = DONE;
          end else if (!play) begin
            w_state_next = PAUSE;
          end
        end
        PAUSE: if (play) w_state_next = PLAY;
        DONE:  w_state_next = DONE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Datapath next values: beat counter, tone sample and phase accumulator.
  always_comb begin
    w_presc_next = r_presc;
    w_beat_next  = ibeatNum;
    w_tone_next  = r_tone_q;
    w_acc_next   = r_acc;
    w_wave_next  = r_wave;
    if (restart) begin
      w_presc_next = '0;
      w_beat_next  = '0;
      w_acc_next   = '0;
      w_wave_next  = 1'b0;
    end else if (r_state == PLAY) begin
      w_presc_next = w_tick ? 32'd0 : r_presc + 32'd1;
      if (w_tick) begin
        if (!w_last) begin
          w_beat_next = ibeatNum + 8'd1;
        end else if (loop_en) begin
          w_beat_next = '0;
        end
      end
      w_tone_next = tone;
      if (w_silent) begin
        w_acc_next  = '0;
        w_wave_next = 1'b0;
      end else if (tone != r_tone_q) begin
        // New note restarts the phase but keeps the current output level.
        w_acc_next = '0;
      end else if (w_sum >= C_CLK) begin
        w_acc_next  = w_sum - C_CLK;
        w_wave_next = ~r_wave;
      end else begin
        w_acc_next = w_sum;
      end
    end
  end

  // Datapath and registered outputs; audio is muted outside PLAY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc  <= '0;
      ibeatNum <= '0;
      r_tone_q <= C_SILENCE;
      r_acc    <= '0;
      r_wave   <= 1'b0;
      audio    <= 1'b0;
      playing  <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_presc  <= w_presc_next;
      ibeatNum <= w_beat_next;
      r_tone_q <= w_tone_next;
      r_acc    <= w_acc_next;
      r_wave   <= w_wave_next;
      audio    <= (w_state_next == PLAY) & w_wave_next;
      playing  <= (w_state_next == PLAY);
      done     <= (w_state_next == DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_score_player
// Description : Directed and randomized stimulus for score_player, checked
//               cycle by cycle against a phase-count reference model.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_score_player;

  localparam int CLK_FREQ       = 1000;
  localparam int BEAT_FREQ      = 10;
  localparam int LAST_BEAT      = 3;
  localparam int SILENCE_THRESH = 20000;
  localparam int BEAT_CYCLES    = CLK_FREQ / BEAT_FREQ;

  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        play = 1'b0;
  logic        restart = 1'b0;
  logic        loop_en = 1'b0;
  logic [31:0] tab [0:3];
  logic [31:0] tone;
  logic [7:0]  ibeatNum;
  logic        audio;
  logic        playing;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode, beat, cycles into beat, held tone, and the
  // waveform as "level at note start" xor parity of completed half periods.
  int     m_mode;
  int     m_beat;
  int     m_cnt;
  longint m_f;
  longint m_k;
  bit     m_base;

  score_player #(
    .CLK_FREQ      (CLK_FREQ),
    .BEAT_FREQ     (BEAT_FREQ),
    .LAST_BEAT     (LAST_BEAT),
    .SILENCE_THRESH(SILENCE_THRESH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .play    (play),
    .restart (restart),
    .loop_en (loop_en),
    .tone    (tone),
    .ibeatNum(ibeatNum),
    .audio   (audio),
    .playing (playing),
    .done    (done)
  );

  // Score ROM stand-in: combinational lookup on the beat index.
  assign tone = tab[ibeatNum[1:0]];

  always #5 clk = ~clk;

  function automatic bit quiet(longint f);
    return (f >= SILENCE_THRESH) || (f == 0) || (2 * f >= CLK_FREQ);
  endfunction

  function automatic bit model_wave();
    return m_base ^ bit'(((m_k * 2 * m_f) / CLK_FREQ) % 2);
  endfunction

  function automatic logic [31:0] rand_tone();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'(SILENCE_THRESH);
      2:       return $urandom_range(500, 30000);
      3:       return 32'd499;
      4:       return 32'd500;
      default: return $urandom_range(1, 499);
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_beat = 0;
    m_cnt  = 0;
    m_f    = SILENCE_THRESH;
    m_k    = 0;
    m_base = 1'b0;
  endtask

  task automatic model_step();
    longint t;
    bit     tick;
    t = tab[m_beat];
    if (rst) begin
      model_reset();
      return;
    end
    if (restart) begin
      m_beat = 0;
      m_cnt  = 0;
      m_k    = 0;
      m_base = 1'b0;
      m_mode = play ? M_PLAY : M_IDLE;
      return;
    end
    case (m_mode)
      M_IDLE:  if (play) m_mode = M_PLAY;
      M_PAUSE: if (play) m_mode = M_PLAY;
      M_PLAY: begin
        tick  = (m_cnt == BEAT_CYCLES - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        if (quiet(m_f)) begin
          m_k    = 0;
          m_base = 1'b0;
        end else if (t != m_f) begin
          m_base = model_wave();
          m_k    = 0;
        end else begin
          m_k++;
        end
        m_f = t;
        if (tick) begin
          if (m_beat < LAST_BEAT) m_beat++;
          else if (loop_en) m_beat = 0;
          else m_mode = M_DONE;
        end
        if (m_mode == M_PLAY && !play) m_mode = M_PAUSE;
      end
      default: ;
    endcase
  endtask

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check(string tag);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {ibeatNum, audio, playing, done};
    exp = {8'(m_beat), (m_mode == M_PLAY) ? model_wave() : 1'b0,
           m_mode == M_PLAY, m_mode == M_DONE};
    cmp(tag, 32'(obs), 32'(exp));
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check(tag);
  endtask

  task automatic run(int n, string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic pulse_restart(string tag);
    restart = 1'b1;
    cyc(tag);
    restart = 1'b0;
  endtask

  // Assert rst between clock edges and confirm outputs clear before any edge.
  task automatic async_reset(string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tab[i] = 32'd50;
    model_reset();
    rst = 1'b1;
    #12;
    check("reset");
    @(negedge clk);
    rst = 1'b0;

    // Constant 50 Hz tone to end of score without looping.
    play = 1'b1;
    run(450, "tone50");
    cmp("s1_done", 32'(done), 32'd1);
    cmp("s1_beat", 32'(ibeatNum), 32'd3);
    cmp("s1_audio", 32'(audio), 32'd0);

    // Restart out of DONE with looping enabled.
    loop_en = 1'b1;
    pulse_restart("restart_done");
    cmp("s5_playing", 32'(playing), 32'd1);
    run(500, "loop");
    cmp("s2_done", 32'(done), 32'd0);

    // Rest on beat 1.
    tab[1] = 32'(SILENCE_THRESH);
    pulse_restart("restart_rest");
    run(400, "rest_beat");

    // Pause mid-beat for 37 cycles.
    for (int i = 0; i < 4; i++) tab[i] = 32'd50;
    pulse_restart("restart_pause");
    run(150, "pre_pause");
    play = 1'b0;
    run(37, "paused");
    play = 1'b1;
    run(120, "resumed");

    // Restart in the middle of a beat while playing.
    run(43, "pre_restart");
    pulse_restart("restart_mid");
    cmp("s5_beat0", 32'(ibeatNum), 32'd0);
    cmp("s5_audio0", 32'(audio), 32'd0);
    run(120, "post_restart");

    // Asynchronous reset mid-note, then resume from IDLE.
    async_reset("async_rst1");
    cmp("s6_playing", 32'(playing), 32'd0);
    run(130, "post_rst");

    // Randomized segments.
    for (int i = 0; i < 4; i++) tab[i] = rand_tone();
    for (int seg = 0; seg < 70; seg++) begin
      play    = ($urandom_range(0, 3) != 0);
      loop_en = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 2) == 0) tab[$urandom_range(0, 3)] = rand_tone();
      if ($urandom_range(0, 5) == 0) pulse_restart("rand_restart");
      if (seg == 35) async_reset("async_rst2");
      run($urandom_range(1, 120), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
